// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction-fetch stage: PC register, IF/ID latch, redirect/stall/halt/fault handling
module fetch_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_WORDS = 16,
  parameter logic [31:0]     HALT_INSTR = 32'h0000_006F
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] instr_address,
  input  logic [31:0]     instruction,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic            instr_valid,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_WORDS);

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_out_n;
  logic [31:0]     instr_n;
  logic            valid_n;
  logic            target_bad;
  logic            next_seq_bad;

  // Word index beyond the memory, computed on the full address so high bits count.
  function automatic logic out_of_range(input logic [XLEN-1:0] a);
    return (a >> 2) >= IMEM_LIMIT;
  endfunction

  assign pc_plus4      = pc + XLEN'(4);
  assign target_bad    = (branch_target[1:0] != 2'b00) || out_of_range(branch_target);
  assign next_seq_bad  = out_of_range(pc_plus4);
  assign instr_address = pc;
  assign halted        = (state == S_HALT);
  assign fault         = (state == S_FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HOLD;
      pc          <= RESET_PC;
      pc_out      <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pc_out      <= pc_out_n;
      instr_out   <= instr_n;
      instr_valid <= valid_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    pc_out_n = pc_out;
    instr_n  = instr_out;
    valid_n  = instr_valid;
    case (state)
      // Memory output is not trustworthy until one edge after reset release.
      S_HOLD: begin
        state_n = S_RUN;
        valid_n = 1'b0;
      end
      S_RUN: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          if (target_bad) state_n = S_FAULT;
          else            pc_n    = branch_target;
        end else if (!stall) begin
          instr_n  = instruction;
          pc_out_n = pc;
          valid_n  = 1'b1;
          if (instruction == HALT_INSTR) state_n = S_HALT;
          else if (next_seq_bad)         state_n = S_FAULT;
          else                           pc_n    = pc_plus4;
        end
      end
      // Terminal states: everything frozen except the valid flag, which drops.
      S_HALT:  valid_n = 1'b0;
      S_FAULT: valid_n = 1'b0;
      default: state_n = S_HOLD;
    endcase
  end

endmodule
